// File: rtl/count_sequencer_if.sv
// count_sequencer_if: command handshake bus between the top-level control and count_sequencer.
interface count_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_mode;
    logic [DIV_W-1:0] prescale;
    modport master(output cmd_valid, cmd_op, cmd_data, cmd_mode, prescale, input cmd_ready);
    modport slave(input cmd_valid, cmd_op, cmd_data, cmd_mode, prescale, output cmd_ready);
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: control FSM driving a counter with prescaled enable ticks, target compare, one-shot or wrap.
module count_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic             mainClock,
    input  logic             reset,
    count_sequencer_if.slave cmd,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             cnt_load,
    output logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    state_t           state, state_n;
    logic [DIV_W-1:0] psc, psc_n, pre, pre_n;
    logic [WIDTH-1:0] target, target_n, load_val_n, proj;
    logic             mode, mode_n, en_n, clr_n, load_n, wrap_n, accept, tick;

    assign cmd.cmd_ready = state != DONE;
    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign tick = state == RUN && !accept && psc == pre;
    // Value the counter will hold once this cycle's pulse lands, so back-to-back ticks never overshoot.
    assign proj = cnt_clr ? '0 : cnt_load ? load_val : cnt_en ? count + WIDTH'(1) : count;

    always_comb begin
        state_n = state;
        psc_n = psc;
        pre_n = pre;
        target_n = target;
        mode_n = mode;
        load_val_n = load_val;
        en_n = 1'b0;
        clr_n = 1'b0;
        load_n = 1'b0;
        wrap_n = 1'b0;
        if (accept) begin
            psc_n = '0;
            load_n = cmd.cmd_op == OP_LOAD;
            clr_n = cmd.cmd_op == OP_CLEAR;
            load_val_n = load_n ? cmd.cmd_data : load_val;
            if (cmd.cmd_op == OP_START) begin
                target_n = cmd.cmd_data;
                mode_n = cmd.cmd_mode;
                pre_n = cmd.prescale;
                state_n = RUN;
            end
            if (cmd.cmd_op == OP_STOP)
                state_n = IDLE;
        end else if (tick) begin
            psc_n = '0;
            en_n = proj != target;
            clr_n = proj == target && mode;
            wrap_n = proj == target && mode;
            state_n = (proj == target && !mode) ? DONE : RUN;
        end else if (state == RUN) begin
            psc_n = psc + DIV_W'(1);
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge mainClock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            psc <= '0;
            pre <= '0;
            target <= '0;
            mode <= 1'b0;
            cnt_en <= 1'b0;
            cnt_clr <= 1'b0;
            cnt_load <= 1'b0;
            load_val <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            state <= state_n;
            psc <= psc_n;
            pre <= pre_n;
            target <= target_n;
            mode <= mode_n;
            cnt_en <= en_n;
            cnt_clr <= clr_n;
            cnt_load <= load_n;
            load_val <= load_val_n;
            busy <= state_n == RUN;
            done <= state_n == DONE;
            wrap <= wrap_n;
        end
    end
endmodule
